hspi_rx_pkt_monitor: RTL

- Sits downstream of the HSPI core's RAM write port, alongside SRAM1KB, in the wire_clk domain.
- Snoops each received packet, counts words, and checks data and address against an incrementing pattern.
- Reports per-packet status.
- In loopback mode, issues the tx_act trigger back to the HSPI core after a fixed idle gap, replacing the free-running idle-counter trigger.

---
 rtl/hspi_rx_pkt_monitor_if.sv | 12 +
 rtl/hspi_rx_pkt_monitor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hspi_rx_pkt_monitor_if.sv
// HSPI RAM write-port bundle snooped by hspi_rx_pkt_monitor.
// The HSPI core side drives it (master); the monitor only observes (slave).
`timescale 1ns/1ps
interface hspi_rx_pkt_monitor_if;
    logic        ram_csn;    // chip select, active low
    logic        ram_wen;    // write enable, active low (0 = write)
    logic [8:0]  ram_addr;   // word address
    logic [15:0] ram_wdata;  // low half of the core's write data

    modport master (output ram_csn, ram_wen, ram_addr, ram_wdata);
    modport slave  (input  ram_csn, ram_wen, ram_addr, ram_wdata);
endinterface

// File: rtl/hspi_rx_pkt_monitor.sv
// HSPI receive-packet monitor (wire_clk domain).
// Snoops the HSPI RAM write port, counts the words of each packet, checks
// data/address against an incrementing pattern, reports per-packet status and,
// in loopback mode, fires a one-cycle tx_act after a fixed idle gap.
// Optional build macro HSPI_RX_CHKSUM_EN adds a 16-bit additive checksum on
// o_rx_sum; without it o_rx_sum is tied to zero.
`timescale 1ns/1ps
module hspi_rx_pkt_monitor #(
    parameter int          MAX_WORDS  = 512,
    parameter int          GAP_CYCLES = 32,
    parameter logic [15:0] SEED       = 16'h0000,
    parameter int          LOOPBACK   = 1
) (
    input  logic                        wire_clk,
    input  logic                        rstn,
    input  logic                        i_rx_act,
    hspi_rx_pkt_monitor_if.slave        ram,
    output logic                        o_tx_act,
    output logic                        o_pkt_done,
    output logic                        o_pkt_err,
    output logic [9:0]                  o_pkt_words,
    output logic [8:0]                  o_first_err_addr,
    output logic [7:0]                  o_err_cnt,
    output logic                        o_busy,
    output logic [15:0]                 o_rx_sum
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_CHECK,
        ST_GAP,
        ST_TRIG
    } state_t;

    localparam logic [9:0]  MAX_N    = 10'(MAX_WORDS);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t      r_state;
    logic        r_sync1, r_sync2, r_sync3;
    logic [9:0]  r_n;
    logic        r_mis;
    logic        r_ovf;
    logic [8:0]  r_first_addr;
    logic [15:0] r_gap_cnt;

    logic        w_wr, w_rise, w_fall, w_enter_rx;
    logic        w_rx_wr, w_counted, w_bad;
    logic [15:0] w_exp_data;
    logic [9:0]  w_n_nxt;
    logic        w_mis_nxt, w_ovf_nxt, w_err_nxt;
    logic [8:0]  w_first_nxt;

    // Bring the asynchronous rx_act pin into wire_clk and keep one delayed copy for edge detection.
    always_ff @(posedge wire_clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the previous stage's old value, forming a real shift chain.
            r_sync1 <= i_rx_act;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Decode edges and compute the packet bookkeeping that a write in this cycle would produce.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no inferred latch).
        w_wr        = ~ram.ram_csn & ~ram.ram_wen;
        w_rise      = r_sync2 & ~r_sync3;
        w_fall      = ~r_sync2 & r_sync3;
        w_enter_rx  = w_rise & ((r_state == ST_IDLE) | (r_state == ST_GAP));
        w_rx_wr     = (r_state == ST_RX) & w_wr;
        w_counted   = w_rx_wr & (r_n != MAX_N);
        w_exp_data  = SEED + {6'b0, r_n};
        w_bad       = 1'b0;
        w_n_nxt     = r_n;
        w_first_nxt = r_first_addr;
        w_ovf_nxt   = r_ovf;
        if (w_counted) begin
            // Writes beyond the RAM depth are flagged as overflow only; they are neither counted nor compared.
            w_bad   = (ram.ram_wdata != w_exp_data) | (ram.ram_addr != r_n[8:0]);
            w_n_nxt = r_n + 10'd1;
        end else if (w_rx_wr) begin
            w_ovf_nxt = 1'b1;
        end
        if (w_bad && !r_mis) begin
            w_first_nxt = ram.ram_addr;
        end
        w_mis_nxt = r_mis | w_bad;
        w_err_nxt = (w_n_nxt == 10'd0) | w_mis_nxt | w_ovf_nxt;
    end

    // Packet state machine; status is latched on the fall-detect edge so it is valid while in CHECK.
    always_ff @(posedge wire_clk or negedge rstn) begin
        if (!rstn) begin
            r_state          <= ST_IDLE;
            r_n              <= '0;
            r_mis            <= 1'b0;
            r_ovf            <= 1'b0;
            r_first_addr     <= '0;
            r_gap_cnt        <= '0;
            o_tx_act         <= 1'b0;
            o_pkt_done       <= 1'b0;
            o_pkt_err        <= 1'b0;
            o_pkt_words      <= '0;
            o_first_err_addr <= '0;
            o_err_cnt        <= '0;
        end else begin
            o_pkt_done <= 1'b0;
            o_tx_act   <= 1'b0;
            if (w_enter_rx) begin
                r_state      <= ST_RX;
                r_n          <= '0;
                r_mis        <= 1'b0;
                r_ovf        <= 1'b0;
                r_first_addr <= '0;
            end else begin
                case (r_state)
                    ST_RX: begin
                        r_n          <= w_n_nxt;
                        r_mis        <= w_mis_nxt;
                        r_ovf        <= w_ovf_nxt;
                        r_first_addr <= w_first_nxt;
                        if (w_fall) begin
                            o_pkt_words      <= w_n_nxt;
                            o_pkt_err        <= w_err_nxt;
                            o_first_err_addr <= w_first_nxt;
                            o_pkt_done       <= 1'b1;
                            if (w_err_nxt && (o_err_cnt != 8'hFF)) begin
                                o_err_cnt <= o_err_cnt + 8'd1;
                            end
                            r_state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        r_gap_cnt <= '0;
                        r_state   <= ((LOOPBACK == 1) && !o_pkt_err) ? ST_GAP : ST_IDLE;
                    end
                    ST_GAP: begin
                        if (r_gap_cnt == GAP_LAST) begin
                            o_tx_act <= 1'b1;
                            r_state  <= ST_TRIG;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 16'd1;
                        end
                    end
                    ST_TRIG: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef HSPI_RX_CHKSUM_EN
    logic [15:0] r_sum;
    logic [15:0] r_rx_sum;

    // Accumulate counted words of the current packet and latch the total alongside the other status.
    always_ff @(posedge wire_clk or negedge rstn) begin
        if (!rstn) begin
            r_sum    <= '0;
            r_rx_sum <= '0;
        end else begin
            if (w_enter_rx) begin
                r_sum <= '0;
            end else if (w_counted) begin
                r_sum <= r_sum + ram.ram_wdata;
            end
            if ((r_state == ST_RX) && w_fall) begin
                r_rx_sum <= w_counted ? (r_sum + ram.ram_wdata) : r_sum;
            end
        end
    end

    assign o_rx_sum = r_rx_sum;
`else
    assign o_rx_sum = 16'h0000;
`endif

    assign o_busy = (r_state != ST_IDLE);

endmodule
